// File: rtl/snake_body.sv
// Snake-body engine: circular segment buffer, step/grow, collisions, pixel stream.
// Define SNAKE_WRAP_EN to make the playfield edges wrap instead of killing the snake.
module snake_body #(
    parameter int X_W          = 8,
    parameter int Y_W          = 7,
    parameter int GRID_W       = 160,
    parameter int GRID_H       = 120,
    parameter int MAX_LEN      = 64,
    parameter int INIT_LEN     = 3,
    parameter int START_X      = 80,
    parameter int START_Y      = 60,
    parameter logic [2:0] BODY_COLOUR  = 3'b010,
    parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         step,
    input  logic [1:0]                   dir,
    input  logic                         grow,
    output logic                         ready,
    output logic                         done,
    output logic                         collision,
    output logic [$clog2(MAX_LEN+1)-1:0] length,
    output logic [X_W-1:0]               head_x,
    output logic [Y_W-1:0]               head_y,
    output logic                         plot,
    output logic [X_W-1:0]               plot_x,
    output logic [Y_W-1:0]               plot_y,
    output logic [2:0]                   plot_colour
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int PW = $clog2(MAX_LEN);

    typedef enum logic [3:0] {
        INIT, IDLE, CALC, SCAN, COMMIT, DRAW_HEAD, ERASE_TAIL, FINISH, DEAD
    } state_t;

    state_t state, nstate;

    logic [X_W-1:0] bx [MAX_LEN];
    logic [Y_W-1:0] by [MAX_LEN];
    logic [PW-1:0]  hp, tp, rd_ptr;
    logic [LW-1:0]  len, cnt, n_cmp, n_d;
    logic [1:0]     cur_dir, dir_l, eff_dir, eff_l;
    logic           grow_l, grow_eff, grow_d, dead;
    logic [X_W-1:0] nx, nx_d, tx, hx;
    logic [Y_W-1:0] ny, ny_d, ty, hy;
    logic           wall, hit, coll_set, accept;

    assign hx     = bx[hp];
    assign hy     = by[hp];
    assign rd_ptr = hp - PW'(cnt);
    assign hit    = (bx[rd_ptr] == nx) && (by[rd_ptr] == ny);
    assign accept = ready && step;

    // Reversing onto the neck is ignored: keep the current heading.
    assign eff_dir = (dir_l == (cur_dir ^ 2'b10)) ? cur_dir : dir_l;
    assign grow_d  = grow_l && (len != LW'(MAX_LEN));
    assign n_d     = grow_d ? len : len - 1'b1;

    always_comb begin
        nx_d = hx;
        ny_d = hy;
        wall = 1'b0;
        unique case (eff_dir)
            2'b00: begin
                ny_d = hy - 1'b1;
                wall = (hy == '0);
`ifdef SNAKE_WRAP_EN
                if (wall) ny_d = Y_W'(GRID_H - 1);
`endif
            end
            2'b01: begin
                nx_d = hx + 1'b1;
                wall = (hx == X_W'(GRID_W - 1));
`ifdef SNAKE_WRAP_EN
                if (wall) nx_d = '0;
`endif
            end
            2'b10: begin
                ny_d = hy + 1'b1;
                wall = (hy == Y_W'(GRID_H - 1));
`ifdef SNAKE_WRAP_EN
                if (wall) ny_d = '0;
`endif
            end
            2'b11: begin
                nx_d = hx - 1'b1;
                wall = (hx == '0);
`ifdef SNAKE_WRAP_EN
                if (wall) nx_d = X_W'(GRID_W - 1);
`endif
            end
        endcase
`ifdef SNAKE_WRAP_EN
        wall = 1'b0;
`endif
    end

    assign coll_set = ((state == CALC) && wall) || ((state == SCAN) && hit);

    always_comb begin
        nstate = state;
        unique case (state)
            INIT:       if (cnt == LW'(INIT_LEN - 1)) nstate = IDLE;
            IDLE:       if (step) nstate = CALC;
            CALC: begin
                if (wall)            nstate = FINISH;
                else if (n_d == '0)  nstate = COMMIT;
                else                 nstate = SCAN;
            end
            SCAN: begin
                if (hit)                         nstate = FINISH;
                else if (cnt == n_cmp - 1'b1)    nstate = COMMIT;
            end
            COMMIT:     nstate = DRAW_HEAD;
            DRAW_HEAD:  nstate = grow_eff ? FINISH : ERASE_TAIL;
            ERASE_TAIL: nstate = FINISH;
            FINISH: begin
                if (dead)      nstate = DEAD;
                else if (step) nstate = CALC;
                else           nstate = IDLE;
            end
            DEAD:       nstate = DEAD;
            default:    nstate = DEAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            hp       <= PW'(INIT_LEN - 1);
            tp       <= '0;
            len      <= LW'(INIT_LEN);
            cnt      <= '0;
            n_cmp    <= '0;
            cur_dir  <= 2'b01;
            dir_l    <= 2'b01;
            eff_l    <= 2'b01;
            grow_l   <= 1'b0;
            grow_eff <= 1'b0;
            dead     <= 1'b0;
            nx       <= '0;
            ny       <= '0;
            tx       <= '0;
            ty       <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < INIT_LEN) begin
                    bx[i] <= X_W'(START_X - INIT_LEN + 1 + i);
                    by[i] <= Y_W'(START_Y);
                end else begin
                    bx[i] <= '0;
                    by[i] <= '0;
                end
            end
        end else begin
            state <= nstate;
            if (accept) begin
                dir_l  <= dir;
                grow_l <= grow;
            end
            if (coll_set) dead <= 1'b1;
            unique case (state)
                INIT: cnt <= cnt + 1'b1;
                CALC: begin
                    cnt      <= '0;
                    nx       <= nx_d;
                    ny       <= ny_d;
                    eff_l    <= eff_dir;
                    grow_eff <= grow_d;
                    n_cmp    <= n_d;
                end
                SCAN: cnt <= cnt + 1'b1;
                COMMIT: begin
                    // Old tail is latched first: at full length the head overwrites it.
                    tx              <= bx[tp];
                    ty              <= by[tp];
                    bx[hp + 1'b1]   <= nx;
                    by[hp + 1'b1]   <= ny;
                    hp              <= hp + 1'b1;
                    cur_dir         <= eff_l;
                    if (grow_eff) len <= len + 1'b1;
                    else          tp  <= tp + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready     = (state == IDLE) || ((state == FINISH) && !dead);
    assign done      = (state == FINISH);
    assign collision = dead;
    assign length    = len;
    assign head_x    = hx;
    assign head_y    = hy;

    always_comb begin
        plot        = 1'b0;
        plot_x      = '0;
        plot_y      = '0;
        plot_colour = 3'b000;
        unique case (state)
            INIT: if (!rst) begin
                plot        = 1'b1;
                plot_x      = bx[rd_ptr];
                plot_y      = by[rd_ptr];
                plot_colour = BODY_COLOUR;
            end
            DRAW_HEAD: begin
                plot        = 1'b1;
                plot_x      = hx;
                plot_y      = hy;
                plot_colour = BODY_COLOUR;
            end
            ERASE_TAIL: begin
                plot        = 1'b1;
                plot_x      = tx;
                plot_y      = ty;
                plot_colour = ERASE_COLOUR;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: init plots, moves, growth, reversal,
// self collision, reset abort and wall behaviour.
module tb_snake_body;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step = 1'b0, w_step = 1'b0;
    logic [1:0] dir = 2'b01, w_dir = 2'b01;
    logic       grow = 1'b0, w_grow = 1'b0;
    logic       ready, done, collision, plot;
    logic       w_ready, w_done, w_collision, w_plot;
    logic [6:0] length, w_length;
    logic [7:0] head_x, plot_x, w_head_x, w_plot_x;
    logic [6:0] head_y, plot_y, w_head_y, w_plot_y;
    logic [2:0] plot_colour, w_plot_colour;

    int checks = 0;
    int failures = 0;
    int dk;
    int ncap;
    logic rdy1;
    logic [7:0] cap_x [4];
    logic [6:0] cap_y [4];
    logic [2:0] cap_c [4];

    always #5 clk = ~clk;

    snake_body dut (
        .clk(clk), .rst(rst), .step(step), .dir(dir), .grow(grow),
        .ready(ready), .done(done), .collision(collision), .length(length),
        .head_x(head_x), .head_y(head_y), .plot(plot), .plot_x(plot_x),
        .plot_y(plot_y), .plot_colour(plot_colour)
    );

    snake_body #(.START_X(159)) wdut (
        .clk(clk), .rst(rst), .step(w_step), .dir(w_dir), .grow(w_grow),
        .ready(w_ready), .done(w_done), .collision(w_collision),
        .length(w_length), .head_x(w_head_x), .head_y(w_head_y),
        .plot(w_plot), .plot_x(w_plot_x), .plot_y(w_plot_y),
        .plot_colour(w_plot_colour)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_step(input bit w, input logic [1:0] d, input logic g);
        if (w) begin
            w_step = 1'b1; w_dir = d; w_grow = g;
        end else begin
            step = 1'b1; dir = d; grow = g;
        end
        tick();
        step = 1'b0;
        w_step = 1'b0;
        rdy1 = w ? w_ready : ready;
        dk = -1;
        ncap = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if ((w ? w_plot : plot) && ncap < 4) begin
                cap_x[ncap] = w ? w_plot_x : plot_x;
                cap_y[ncap] = w ? w_plot_y : plot_y;
                cap_c[ncap] = w ? w_plot_colour : plot_colour;
                ncap++;
            end
            if (w ? w_done : done) begin
                dk = k;
                break;
            end
        end
    endtask

    task automatic chk_plot(input string tag, input int i, input logic [7:0] x,
                            input logic [6:0] y, input logic [2:0] c);
        chk({tag, "_x"}, cap_x[i], x);
        chk({tag, "_y"}, cap_y[i], y);
        chk({tag, "_c"}, cap_c[i], c);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ready", ready, 0);
        chk("rst_done", done, 0);
        chk("rst_coll", collision, 0);
        chk("rst_plot", plot, 0);
        chk("rst_pcol", plot_colour, 0);
        chk("rst_len", length, 3);
        chk("rst_hx", head_x, 80);
        chk("rst_hy", head_y, 60);
        rst = 1'b0;
        #1;
        chk("init0_p", plot, 1);
        chk("init0_x", plot_x, 80);
        chk("init0_c", plot_colour, 3'b010);
        tick();
        chk("init1_x", plot_x, 79);
        chk("init1_y", plot_y, 60);
        tick();
        chk("init2_p", plot, 1);
        chk("init2_x", plot_x, 78);
        tick();
        chk("idle_ready", ready, 1);
        chk("idle_plot", plot, 0);
        chk("idle_len", length, 3);

        do_step(0, 2'b01, 0);
        chk("mv_rdy_e1", rdy1, 0);
        chk("mv_dk", dk, 6);
        chk("mv_ncap", ncap, 2);
        chk_plot("mv_head", 0, 81, 60, 3'b010);
        chk_plot("mv_tail", 1, 78, 60, 3'b000);
        chk("mv_ready", ready, 1);
        chk("mv_len", length, 3);
        chk("mv_hx", head_x, 81);

        do_step(0, 2'b00, 1);
        chk("gr_dk", dk, 6);
        chk("gr_ncap", ncap, 1);
        chk_plot("gr_head", 0, 81, 59, 3'b010);
        chk("gr_len", length, 4);
        chk("gr_hy", head_y, 59);

        do_step(0, 2'b01, 0);
        chk("r1_dk", dk, 7);
        chk_plot("r1_tail", 1, 79, 60, 3'b000);

        do_step(0, 2'b11, 0);
        chk("rev_dk", dk, 7);
        chk("rev_hx", head_x, 83);
        chk("rev_hy", head_y, 59);
        chk_plot("rev_tail", 1, 80, 60, 3'b000);

        do_step(0, 2'b01, 1);
        chk("g5_dk", dk, 7);
        chk("g5_len", length, 5);
        do_step(0, 2'b00, 0);
        chk("up_dk", dk, 8);
        chk_plot("up_tail", 1, 81, 60, 3'b000);
        do_step(0, 2'b11, 0);
        chk("lf_dk", dk, 8);
        chk("lf_hx", head_x, 83);
        chk("lf_hy", head_y, 58);
        do_step(0, 2'b10, 0);
        chk("sc_dk", dk, 5);
        chk("sc_ncap", ncap, 0);
        chk("sc_coll", collision, 1);
        chk("sc_hy", head_y, 58);
        tick();
        chk("dead_ready", ready, 0);
        chk("dead_done", done, 0);
        step = 1'b1;
        dir = 2'b00;
        ncap = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done || plot || ready) ncap++;
        end
        step = 1'b0;
        chk("dead_quiet", ncap, 0);
        chk("dead_hy", head_y, 58);
        chk("dead_len", length, 5);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("re_ready", ready, 1);
        chk("re_coll", collision, 0);
        step = 1'b1;
        dir = 2'b01;
        tick();
        step = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("ab_hx", head_x, 80);
        chk("ab_len", length, 3);
        chk("ab_plot", plot, 0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("ab_ready", ready, 1);
        chk("w_ready", w_ready, 1);

        do_step(1, 2'b01, 0);
`ifdef SNAKE_WRAP_EN
        chk("w_dk", dk, 6);
        chk("w_coll", w_collision, 0);
        chk_plot("w_head", 0, 0, 60, 3'b010);
        chk_plot("w_tail", 1, 157, 60, 3'b000);
        chk("w_hx", w_head_x, 0);
`else
        chk("w_dk", dk, 1);
        chk("w_coll", w_collision, 1);
        chk("w_ncap", ncap, 0);
        chk("w_hx", w_head_x, 159);
        tick();
        chk("w_dead", w_ready, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
